reg_file_wb: RTL and testbench
==============================

# reg_file_wb

Parametrised integer register file with an integrated write-back formatter and load scoreboard. It is the next generation of the CPU's decode-stage register bank. It provides two combinational read ports and two write ports: port A carries ALU/JAL results, port B carries load returns with lb/lbu/lh/lhu/lw extension. It tracks outstanding loads per register and raises a hazard to stall issue, and an optional write-to-read bypass is available. It sits between the instruction decoder, the ALU result path and the data-memory return path.

## Interface
Parameters:
- XLEN, 32, data width; multiple of 16.
- NREG, 32, number of registers; power of two, at least 2. AW = clog2(NREG) is local.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- rs1_addr, rs2_addr  in  AW  read addresses
- rs1_data, rs2_data  out  XLEN  read data (combinational)
- wa_en  in  1  port A write enable (ALU / JAL link)
- wa_rd  in  AW  port A destination
- wa_data  in  XLEN  port A data, written unmodified
- ld_issue  in  1  a load to ld_issue_rd is dispatched this cycle
- ld_issue_rd  in  AW  load destination
- wb_en  in  1  port B load return valid
- wb_rd  in  AW  port B destination
- wb_raw  in  XLEN  raw memory word
- wb_funct3  in  3  000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; others treated as lw
- wb_off  in  clog2(XLEN/8)  byte offset of the access within the word
- hazard  out  1  rs1 or rs2 waits on an outstanding load
- busy_vec  out  NREG  scoreboard bits; bit 0 is always 0

## Operation
- Register 0 is hardwired to zero. Writes to it are discarded, it never becomes busy, and it never raises a hazard.
- Port B formatting:
  - Byte = wb_raw[8*wb_off +: 8]. lb sign-extends it to XLEN; lbu zero-extends it.
  - Half = wb_raw[16*(wb_off>>1) +: 16]. wb_off[0] is ignored (no misalignment trap). lh sign-extends; lhu zero-extends.
  - lw passes wb_raw unchanged.
- Write priority: when wa_en and wb_en target the same register in the same cycle, port A wins. Port A is the younger instruction. Port B data is dropped, but its busy-clear still happens.
- Scoreboard, per register r≠0, at the clock edge:
  - ld_issue with rd=r sets busy[r].
  - Otherwise, wb_en with wb_rd=r clears busy[r].
  - When ld_issue and wb_en hit the same r in the same cycle, busy stays 1.
  - Port A writes do not touch busy.
- hazard = (busy[rs1_addr] & ~fwd1) | (busy[rs2_addr] & ~fwd2).
  - fwdN = BYPASS & wb_en & (wb_rd == rsN_addr).
  - Register 0 never raises a hazard.
- Read path for port N:
  - If rsN_addr = 0, the result is 0.
  - Else, with BYPASS=1, a matching wa_en supplies wa_data. Failing that, a matching wb_en supplies the formatted port B data.
  - Otherwise the result is the stored value.
- busy_vec reflects registered state only; there is no bypass on it.

## Timing
- Reset: while reset=1 at an edge, all registers are cleared to 0 and all busy bits to 0. After reset, rs1_data=rs2_data=0, hazard=0 and busy_vec=0. Reset overrides any write, issue or return in the same cycle. Loads outstanding at reset are forgotten, and a later return for them writes normally.
- Write latency: data written at edge k is readable from the register array from cycle k+1. With BYPASS=1 it is already visible in cycle k, combinationally.
- Busy latency: busy set by ld_issue in cycle k is visible from cycle k+1. hazard for a dependent read in the same cycle k is 0; the decoder owns that back-to-back case.
- There is no handshake on port B: every wb_en is accepted. A return to a register that is not busy is written and leaves busy at 0.
- A second ld_issue to an already busy register keeps it busy. The first return then clears it; the scoreboard tracks only one load per register.

## Test plan
- Reset: preload r5=0xDEADBEEF, then assert reset for 1 cycle → r5 reads 0, busy_vec=0, hazard=0.
- x0 protection: wa_en with wa_rd=0 and wa_data=0x12345678 → rs1_addr=0 reads 0. ld_issue with rd=0 → busy_vec[0]=0.
- Load formatting with wb_raw=0x80FF7F01:
  - lb, off 1 → 0x0000007F
  - lb, off 2 → 0xFFFFFFFF
  - lbu, off 3 → 0x00000080
  - lh, off 2 → 0xFFFF80FF
  - lhu, off 0 → 0x00007F01
  - lw → 0x80FF7F01
- Scoreboard and stall: ld_issue with rd=7, then rs2_addr=7 → hazard=1 until the return. With BYPASS=1, wb_en with rd=7 and lw 0x55 makes hazard=0 and rs2_data=0x55 in that same cycle. With BYPASS=0, hazard stays 1 during that cycle and falls to 0 the next.
- Collision: wa_en(rd=3, 0xA) and wb_en(rd=3, lw 0xB) in the same cycle, with r3 busy → r3 = 0xA next cycle and busy[3]=0. ld_issue(rd=4) and wb_en(rd=4) in the same cycle → busy[4]=1.
- Parameter sweep: run with NREG=16, XLEN=64, BYPASS=0. lhu with off 6 on raw 0xBEEF000000000000 → 0x000000000000BEEF. Same-cycle read of a just-written register returns the old value.

Source files
------------

// File: rtl/reg_file_wb.sv
// Integer register file with an ALU write port, a formatted load-return write port,
// a one-bit-per-register load scoreboard and optional write-to-read forwarding.
module reg_file_wb #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREG),
    localparam int OW    = $clog2(XLEN / 8)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    input  logic            wa_en,
    input  logic [AW-1:0]   wa_rd,
    input  logic [XLEN-1:0] wa_data,
    input  logic            ld_issue,
    input  logic [AW-1:0]   ld_issue_rd,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_raw,
    input  logic [2:0]      wb_funct3,
    input  logic [OW-1:0]   wb_off,
    output logic            hazard,
    output logic [NREG-1:0] busy_vec
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [XLEN-1:0] regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;

    // ------------------------------------------------------------------
    // Load-return formatter
    // ------------------------------------------------------------------
    logic [OW+2:0]   byte_sel;
    logic [OW+2:0]   half_sel;
    logic [7:0]      wb_byte;
    logic [15:0]     wb_half;
    logic [XLEN-1:0] wb_fmt;

    // Halfword select drops offset bit 0: a misaligned lh/lhu reads the containing half.
    always_comb begin
        byte_sel    = {wb_off, 3'b000};
        half_sel    = {wb_off, 3'b000};
        half_sel[3] = 1'b0;
    end

    assign wb_byte = wb_raw[byte_sel +: 8];
    assign wb_half = wb_raw[half_sel +: 16];

    always_comb begin
        wb_fmt = wb_raw;
        case (wb_funct3)
            F3_LB:   wb_fmt = {{(XLEN-8){wb_byte[7]}}, wb_byte};
            F3_LH:   wb_fmt = {{(XLEN-16){wb_half[15]}}, wb_half};
            F3_LBU:  wb_fmt = {{(XLEN-8){1'b0}}, wb_byte};
            F3_LHU:  wb_fmt = {{(XLEN-16){1'b0}}, wb_half};
            default: wb_fmt = wb_raw;
        endcase
    end

    // ------------------------------------------------------------------
    // Write ports. Port B has no back-pressure: every wb_en beat is taken
    // in the cycle it is presented. On a same-register collision port A
    // (the younger instruction) owns the data.
    // ------------------------------------------------------------------
    logic wa_write;
    logic wb_write;

    assign wa_write = wa_en && (wa_rd != '0);
    assign wb_write = wb_en && (wb_rd != '0) && !(wa_en && (wa_rd == wb_rd));

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wa_write) begin
                regs[wa_rd] <= wa_data;
            end
            if (wb_write) begin
                regs[wb_rd] <= wb_fmt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Scoreboard: issue beats return on the same register, so the set is
    // applied after the clear. Port A never touches busy.
    // ------------------------------------------------------------------
    always_comb begin
        busy_next = busy;
        if (wb_en) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (ld_issue) begin
            busy_next[ld_issue_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;

    // ------------------------------------------------------------------
    // Read ports and hazard
    // ------------------------------------------------------------------
    logic [AW-1:0]   rd_addr [2];
    logic [XLEN-1:0] rd_val  [2];
    logic [1:0]      fwd_b;
    logic [1:0]      fwd_a;
    logic [1:0]      wait_ld;

    assign rd_addr[0] = rs1_addr;
    assign rd_addr[1] = rs2_addr;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            fwd_a[p]   = (BYPASS != 0) && wa_en && (wa_rd == rd_addr[p]);
            fwd_b[p]   = (BYPASS != 0) && wb_en && (wb_rd == rd_addr[p]);
            wait_ld[p] = busy[rd_addr[p]] && !fwd_b[p];
            if (rd_addr[p] == '0) begin
                rd_val[p] = '0;
            end else if (fwd_a[p]) begin
                rd_val[p] = wa_data;
            end else if (fwd_b[p]) begin
                rd_val[p] = wb_fmt;
            end else begin
                rd_val[p] = regs[rd_addr[p]];
            end
        end
    end

    assign rs1_data = rd_val[0];
    assign rs2_data = rd_val[1];
    assign hazard   = |wait_ld;

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed bench for reg_file_wb: a default instance (XLEN=32, NREG=32, BYPASS=1) and a
// swept instance (XLEN=64, NREG=16, BYPASS=0); expectations are queued and checked by a monitor.
module tb_reg_file_wb;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // ---------------- instance A: defaults ----------------
    logic [4:0]  a_rs1_addr, a_rs2_addr, a_wa_rd, a_ld_issue_rd, a_wb_rd;
    logic [31:0] a_rs1_data, a_rs2_data, a_wa_data, a_wb_raw;
    logic        a_wa_en, a_ld_issue, a_wb_en, a_hazard;
    logic [2:0]  a_wb_funct3;
    logic [1:0]  a_wb_off;
    logic [31:0] a_busy_vec;

    reg_file_wb dut_a (
        .clk(clk), .reset(reset),
        .rs1_addr(a_rs1_addr), .rs2_addr(a_rs2_addr),
        .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
        .wa_en(a_wa_en), .wa_rd(a_wa_rd), .wa_data(a_wa_data),
        .ld_issue(a_ld_issue), .ld_issue_rd(a_ld_issue_rd),
        .wb_en(a_wb_en), .wb_rd(a_wb_rd), .wb_raw(a_wb_raw),
        .wb_funct3(a_wb_funct3), .wb_off(a_wb_off),
        .hazard(a_hazard), .busy_vec(a_busy_vec)
    );

    // ---------------- instance B: sweep ----------------
    logic [3:0]  b_rs1_addr, b_rs2_addr, b_wa_rd, b_ld_issue_rd, b_wb_rd;
    logic [63:0] b_rs1_data, b_rs2_data, b_wa_data, b_wb_raw;
    logic        b_wa_en, b_ld_issue, b_wb_en, b_hazard;
    logic [2:0]  b_wb_funct3;
    logic [2:0]  b_wb_off;
    logic [15:0] b_busy_vec;

    reg_file_wb #(.XLEN(64), .NREG(16), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset),
        .rs1_addr(b_rs1_addr), .rs2_addr(b_rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .wa_en(b_wa_en), .wa_rd(b_wa_rd), .wa_data(b_wa_data),
        .ld_issue(b_ld_issue), .ld_issue_rd(b_ld_issue_rd),
        .wb_en(b_wb_en), .wb_rd(b_wb_rd), .wb_raw(b_wb_raw),
        .wb_funct3(b_wb_funct3), .wb_off(b_wb_off),
        .hazard(b_hazard), .busy_vec(b_busy_vec)
    );

    // ---------------- scoreboard ----------------
    localparam int K_A_RS1 = 0, K_A_RS2 = 1, K_A_HAZ = 2, K_A_BUSY = 3;
    localparam int K_B_RS1 = 4, K_B_RS2 = 5, K_B_HAZ = 6, K_B_BUSY = 7;

    typedef struct {
        int          kind;
        logic [63:0] val;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic logic [63:0] observe(input int kind);
        case (kind)
            K_A_RS1:  return {32'b0, a_rs1_data};
            K_A_RS2:  return {32'b0, a_rs2_data};
            K_A_HAZ:  return {63'b0, a_hazard};
            K_A_BUSY: return {32'b0, a_busy_vec};
            K_B_RS1:  return b_rs1_data;
            K_B_RS2:  return b_rs2_data;
            K_B_HAZ:  return {63'b0, b_hazard};
            K_B_BUSY: return {48'b0, b_busy_vec};
            default:  return 64'hx;
        endcase
    endfunction

    // Monitor: every expectation queued during a cycle is checked at that cycle's falling edge.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            logic [63:0] act;
            e   = exp_q.pop_front();
            act = observe(e.kind);
            n_cmp++;
            if (act !== e.val) begin
                n_err++;
                $display("FAIL %s: got %h, expected %h", e.name, act, e.val);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic expect_v(input int kind, input logic [63:0] v, input string name);
        exp_t e;
        e.kind = kind;
        e.val  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic a_idle();
        a_rs1_addr = '0; a_rs2_addr = '0;
        a_wa_en = 1'b0; a_wa_rd = '0; a_wa_data = '0;
        a_ld_issue = 1'b0; a_ld_issue_rd = '0;
        a_wb_en = 1'b0; a_wb_rd = '0; a_wb_raw = '0; a_wb_funct3 = 3'b010; a_wb_off = '0;
    endtask

    task automatic b_idle();
        b_rs1_addr = '0; b_rs2_addr = '0;
        b_wa_en = 1'b0; b_wa_rd = '0; b_wa_data = '0;
        b_ld_issue = 1'b0; b_ld_issue_rd = '0;
        b_wb_en = 1'b0; b_wb_rd = '0; b_wb_raw = '0; b_wb_funct3 = 3'b010; b_wb_off = '0;
    endtask

    task automatic a_ret(input logic [4:0] rd, input logic [31:0] raw,
                         input logic [2:0] f3, input logic [1:0] off);
        a_wb_en = 1'b1; a_wb_rd = rd; a_wb_raw = raw; a_wb_funct3 = f3; a_wb_off = off;
    endtask

    // Load-format vectors on raw 0x80FF7F01 (bytes 01,7F,FF,80 from offset 0).
    logic [2:0]  fv_f3  [8] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b001, 3'b111};
    logic [1:0]  fv_off [8] = '{2'd1,   2'd2,   2'd3,   2'd2,   2'd0,   2'd0,   2'd3,   2'd1};
    logic [31:0] fv_exp [8] = '{32'h0000007F, 32'hFFFFFFFF, 32'h00000080, 32'hFFFF80FF,
                                32'h00007F01, 32'h80FF7F01, 32'hFFFF80FF, 32'h80FF7F01};

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b1;
        a_idle();
        b_idle();
        step();
        step();
        reset = 1'b0;

        // Reset state on both instances
        a_rs1_addr = 5'd5; a_rs2_addr = 5'd9;
        b_rs1_addr = 4'd5;
        expect_v(K_A_RS1, 64'd0, "a_reset_rs1");
        expect_v(K_A_RS2, 64'd0, "a_reset_rs2");
        expect_v(K_A_HAZ, 64'd0, "a_reset_hazard");
        expect_v(K_A_BUSY, 64'd0, "a_reset_busy");
        expect_v(K_B_RS1, 64'd0, "b_reset_rs1");
        expect_v(K_B_BUSY, 64'd0, "b_reset_busy");
        step();

        // Preload r5 (forwarded in the same cycle), then read it from storage
        a_wa_en = 1'b1; a_wa_rd = 5'd5; a_wa_data = 32'hDEADBEEF;
        expect_v(K_A_RS1, 64'hDEADBEEF, "a_wa_bypass_r5");
        step();
        a_wa_en = 1'b0;
        a_ld_issue = 1'b1; a_ld_issue_rd = 5'd9;
        expect_v(K_A_RS1, 64'hDEADBEEF, "a_stored_r5");
        step();

        // Reset pulse, with a competing write to r5 in the same cycle
        a_ld_issue = 1'b0;
        reset = 1'b1;
        a_wa_en = 1'b1; a_wa_rd = 5'd5; a_wa_data = 32'h00001234;
        expect_v(K_A_BUSY, 64'h0000_0200, "a_busy_r9_before_reset");
        step();
        reset = 1'b0;
        a_wa_en = 1'b0;
        expect_v(K_A_RS1, 64'd0, "a_r5_after_reset");
        expect_v(K_A_BUSY, 64'd0, "a_busy_after_reset");
        expect_v(K_A_HAZ, 64'd0, "a_hazard_after_reset");
        step();

        // x0 protection
        a_rs1_addr = 5'd0;
        a_wa_en = 1'b1; a_wa_rd = 5'd0; a_wa_data = 32'h12345678;
        a_ld_issue = 1'b1; a_ld_issue_rd = 5'd0;
        expect_v(K_A_RS1, 64'd0, "a_x0_same_cycle");
        step();
        a_wa_en = 1'b0; a_ld_issue = 1'b0;
        expect_v(K_A_RS1, 64'd0, "a_x0_after_write");
        expect_v(K_A_BUSY, 64'd0, "a_x0_not_busy");
        step();

        // Load formatting: each vector lands in r10+i, checked through the bypass
        for (int i = 0; i < 8; i++) begin
            a_rs1_addr = 5'(10 + i);
            a_ret(5'(10 + i), 32'h80FF7F01, fv_f3[i], fv_off[i]);
            expect_v(K_A_RS1, {32'b0, fv_exp[i]}, $sformatf("a_fmt_bypass_%0d", i));
            step();
        end
        a_wb_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            a_rs2_addr = 5'(10 + i);
            expect_v(K_A_RS2, {32'b0, fv_exp[i]}, $sformatf("a_fmt_stored_%0d", i));
            step();
        end

        // Scoreboard and stall
        a_ld_issue = 1'b1; a_ld_issue_rd = 5'd7;
        a_rs2_addr = 5'd7;
        expect_v(K_A_HAZ, 64'd0, "a_issue_cycle_no_hazard");
        step();
        a_ld_issue = 1'b0;
        expect_v(K_A_HAZ, 64'd1, "a_hazard_r7_1");
        expect_v(K_A_BUSY, 64'h0000_0080, "a_busy_r7");
        step();
        expect_v(K_A_HAZ, 64'd1, "a_hazard_r7_2");
        step();
        a_ret(5'd7, 32'h00000055, 3'b010, 2'd0);
        expect_v(K_A_HAZ, 64'd0, "a_return_bypass_hazard");
        expect_v(K_A_RS2, 64'h55, "a_return_bypass_data");
        expect_v(K_A_BUSY, 64'h0000_0080, "a_busy_during_return");
        step();
        a_wb_en = 1'b0;
        expect_v(K_A_HAZ, 64'd0, "a_after_return_hazard");
        expect_v(K_A_RS2, 64'h55, "a_after_return_data");
        expect_v(K_A_BUSY, 64'd0, "a_after_return_busy");
        step();

        // Collision: port A wins data, port B still clears busy
        a_ld_issue = 1'b1; a_ld_issue_rd = 5'd3;
        step();
        a_ld_issue = 1'b0;
        a_rs1_addr = 5'd3;
        a_wa_en = 1'b1; a_wa_rd = 5'd3; a_wa_data = 32'h0000000A;
        a_ret(5'd3, 32'h0000000B, 3'b010, 2'd0);
        expect_v(K_A_RS1, 64'hA, "a_collision_bypass");
        expect_v(K_A_BUSY, 64'h0000_0008, "a_collision_busy_before");
        step();
        a_wa_en = 1'b0; a_wb_en = 1'b0;
        expect_v(K_A_RS1, 64'hA, "a_collision_stored");
        expect_v(K_A_BUSY, 64'd0, "a_collision_busy_after");
        step();

        // Same-cycle issue and return on r4 keeps it busy; the return data is written
        a_ld_issue = 1'b1; a_ld_issue_rd = 5'd4;
        a_ret(5'd4, 32'h00000077, 3'b010, 2'd0);
        step();
        a_ld_issue = 1'b0; a_wb_en = 1'b0;
        a_rs1_addr = 5'd4;
        expect_v(K_A_BUSY, 64'h0000_0010, "a_issue_return_busy");
        expect_v(K_A_RS1, 64'h77, "a_issue_return_data");
        expect_v(K_A_HAZ, 64'd1, "a_issue_return_hazard");
        step();
        a_idle();

        // ---------------- swept instance: XLEN=64, NREG=16, BYPASS=0 ----------------
        b_rs1_addr = 4'd2;
        b_wb_en = 1'b1; b_wb_rd = 4'd2; b_wb_raw = 64'hBEEF000000000000;
        b_wb_funct3 = 3'b101; b_wb_off = 3'd6;
        expect_v(K_B_RS1, 64'd0, "b_lhu_no_bypass");
        step();
        b_wb_en = 1'b0;
        expect_v(K_B_RS1, 64'h000000000000BEEF, "b_lhu_off6");
        step();

        b_rs2_addr = 4'd3;
        b_wa_en = 1'b1; b_wa_rd = 4'd3; b_wa_data = 64'h1122334455667788;
        expect_v(K_B_RS2, 64'd0, "b_wa_old_value");
        step();
        b_wa_en = 1'b0;
        expect_v(K_B_RS2, 64'h1122334455667788, "b_wa_stored");
        step();

        b_rs1_addr = 4'd8;
        b_wb_en = 1'b1; b_wb_rd = 4'd8; b_wb_raw = 64'h8000000000000000;
        b_wb_funct3 = 3'b000; b_wb_off = 3'd7;
        step();
        b_rs2_addr = 4'd9;
        b_wb_rd = 4'd9; b_wb_funct3 = 3'b001; b_wb_off = 3'd7;
        expect_v(K_B_RS1, 64'hFFFFFFFFFFFFFF80, "b_lb_off7");
        step();
        b_wb_en = 1'b0;
        expect_v(K_B_RS2, 64'hFFFFFFFFFFFF8000, "b_lh_off7");
        step();

        b_ld_issue = 1'b1; b_ld_issue_rd = 4'd7;
        b_rs2_addr = 4'd7;
        step();
        b_ld_issue = 1'b0;
        expect_v(K_B_HAZ, 64'd1, "b_hazard_r7");
        expect_v(K_B_BUSY, 64'h0080, "b_busy_r7");
        step();
        b_wb_en = 1'b1; b_wb_rd = 4'd7; b_wb_raw = 64'h55; b_wb_funct3 = 3'b010; b_wb_off = 3'd0;
        expect_v(K_B_HAZ, 64'd1, "b_return_cycle_hazard");
        expect_v(K_B_RS2, 64'd0, "b_return_cycle_data");
        step();
        b_wb_en = 1'b0;
        expect_v(K_B_HAZ, 64'd0, "b_after_return_hazard");
        expect_v(K_B_RS2, 64'h55, "b_after_return_data");
        expect_v(K_B_BUSY, 64'd0, "b_after_return_busy");
        step();

        step();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
